// File: rtl/fetch_queue_if.sv
// Fetch-side push port and decode-side pop port of the fetch queue.
// The queue is the slave; the fetch stage and decode stage together act as master.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             fq_valid_i;
  logic [31:0]      fq_pc_i;
  logic [31:0]      fq_inst_i;
  logic             fq_ready_o;
  logic             dec_valid_o;
  logic [31:0]      dec_pc_o;
  logic [31:0]      dec_inst_o;
  logic             dec_ready_i;
  logic [PTR_W:0]   count_o;

  modport slave (
    input  fq_valid_i,
    input  fq_pc_i,
    input  fq_inst_i,
    output fq_ready_o,
    output dec_valid_o,
    output dec_pc_o,
    output dec_inst_o,
    input  dec_ready_i,
    output count_o
  );

  modport master (
    output fq_valid_i,
    output fq_pc_i,
    output fq_inst_i,
    input  fq_ready_o,
    input  dec_valid_o,
    input  dec_pc_o,
    input  dec_inst_o,
    output dec_ready_i,
    input  count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction FIFO with first-word fall-through, bubble drop
// and single-cycle flush on PC redirect.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   cnt_q;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic dec_valid;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign bus.fq_ready_o = !full;

  // Reset gates the head like flush does so nothing is consumed in a reset cycle.
  assign dec_valid       = !empty && !flush_i && !rst_i;
  assign bus.dec_valid_o = dec_valid;

  assign push = bus.fq_valid_i && !full && (bus.fq_inst_i != 32'h0)
                && !flush_i && !rst_i;
  assign pop  = dec_valid && bus.dec_ready_i;

  assign bus.dec_pc_o   = empty ? 32'h0 : pc_mem[rd_q];
  assign bus.dec_inst_o = empty ? 32'h0 : inst_mem[rd_q];
  assign bus.count_o    = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop)  rd_q <= rd_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is never cleared; stale words are hidden by the empty mux above.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_q]   <= bus.fq_pc_i;
      inst_mem[wr_q] <= bus.fq_inst_i;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: accepted pushes are queued, decode pops are
// compared in order, and occupancy/handshake flags are checked every cycle.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  int model_cnt = 0;
  bit mon_en = 1'b0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-cycle model, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_valid;
      bit do_push;
      bit do_pop;
      logic [63:0] head;
      exp_valid = (model_cnt != 0) && !flush && !rst;
      check("count", 64'(bus.count_o), 64'(model_cnt));
      check("fq_ready", 64'(bus.fq_ready_o), 64'(model_cnt != DEPTH));
      check("dec_valid", 64'(bus.dec_valid_o), 64'(exp_valid));
      if (model_cnt == 0)
        check("empty_out", {bus.dec_pc_o, bus.dec_inst_o}, 64'h0);
      do_pop  = exp_valid && bus.dec_ready_i;
      do_push = bus.fq_valid_i && (model_cnt != DEPTH) && (bus.fq_inst_i != 32'h0)
                && !flush && !rst;
      if (do_pop) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'h1);
        if (sb.size() != 0) begin
          head = sb.pop_front();
          check("dec_data", {bus.dec_pc_o, bus.dec_inst_o}, head);
          $display("pop  pc=%h inst=%h", bus.dec_pc_o, bus.dec_inst_o);
        end
      end
      if (do_push) begin
        sb.push_back({bus.fq_pc_i, bus.fq_inst_i});
        $display("push pc=%h inst=%h", bus.fq_pc_i, bus.fq_inst_i);
      end
      if (rst || flush) begin
        sb.delete();
        model_cnt = 0;
        $display("clear rst=%0b flush=%0b", rst, flush);
      end else begin
        model_cnt = model_cnt + int'(do_push) - int'(do_pop);
      end
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the next edge.
  task automatic step(bit v, logic [31:0] pc, logic [31:0] inst, bit rdy);
    bus.fq_valid_i  = v;
    bus.fq_pc_i     = pc;
    bus.fq_inst_i   = inst;
    bus.dec_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    bus.fq_valid_i  = 1'b0;
    bus.fq_pc_i     = 32'h0;
    bus.fq_inst_i   = 32'h0;
    bus.dec_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_count", 64'(bus.count_o), 64'h0);
    check("rst_dec_valid", 64'(bus.dec_valid_o), 64'h0);
    check("rst_fq_ready", 64'(bus.fq_ready_o), 64'h1);
    check("rst_dec_inst", 64'(bus.dec_inst_o), 64'h0);
    check("rst_dec_pc", 64'(bus.dec_pc_o), 64'h0);
    mon_en = 1'b1;

    // In-order stream with decode always ready
    step(1'b1, 32'h0, 32'h00000013, 1'b1);
    check("stream_visible_pc", 64'(bus.dec_pc_o), 64'h0);
    check("stream_cnt_le1", 64'(bus.count_o <= 1), 64'h1);
    step(1'b1, 32'h4, 32'h00100093, 1'b1);
    check("stream_cnt_le1", 64'(bus.count_o <= 1), 64'h1);
    step(1'b1, 32'h8, 32'h00200113, 1'b1);
    check("stream_cnt_le1", 64'(bus.count_o <= 1), 64'h1);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("stream_drained", 64'(bus.count_o), 64'h0);

    // Fill past capacity with decode stalled
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h100 + 32'(4 * i), 32'h00500013 + 32'(i << 20), 1'b0);
      if (i == 3) begin
        check("fill_ready_low", 64'(bus.fq_ready_o), 64'h0);
        check("fill_count4", 64'(bus.count_o), 64'h4);
      end
    end
    check("fill_fifth_dropped", 64'(bus.count_o), 64'h4);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("unfill_count3", 64'(bus.count_o), 64'h3);
    check("unfill_ready", 64'(bus.fq_ready_o), 64'h1);
    check("unfill_head_pc", 64'(bus.dec_pc_o), 64'h104);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1);

    // Bubbles are accepted but never stored
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h200 + 32'(4 * i), (i % 2 == 0) ? 32'h00000013 : 32'h0, 1'b0);
    check("bubble_count3", 64'(bus.count_o), 64'h3);
    check("bubble_ready", 64'(bus.fq_ready_o), 64'h1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1);

    // Wrap-around at occupancy 2
    step(1'b1, 32'h0, 32'h00000013, 1'b0);
    step(1'b1, 32'h4, 32'h00000093, 1'b0);
    for (int i = 2; i < 10; i++) begin
      step(1'b1, 32'(4 * i), 32'h00000013 + 32'(i << 7), 1'b1);
      check("wrap_count2", 64'(bus.count_o), 64'h2);
    end
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1);
    check("wrap_drained", 64'(bus.count_o), 64'h0);

    // Flush with three entries queued, fetch and decode both active
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h300 + 32'(4 * i), 32'h00700013, 1'b0);
    check("preflush_count3", 64'(bus.count_o), 64'h3);
    bus.fq_valid_i  = 1'b1;
    bus.fq_pc_i     = 32'h400;
    bus.fq_inst_i   = 32'h00800013;
    bus.dec_ready_i = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_dec_valid", 64'(bus.dec_valid_o), 64'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.fq_valid_i  = 1'b0;
    bus.dec_ready_i = 1'b0;
    check("flush_count0", 64'(bus.count_o), 64'h0);
    check("flush_dec_valid_after", 64'(bus.dec_valid_o), 64'h0);

    // Same scenario with reset instead of flush
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h500 + 32'(4 * i), 32'h00900013, 1'b0);
    check("prerst_count3", 64'(bus.count_o), 64'h3);
    bus.fq_valid_i  = 1'b1;
    bus.fq_pc_i     = 32'h600;
    bus.fq_inst_i   = 32'h00a00013;
    bus.dec_ready_i = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_mid_dec_valid", 64'(bus.dec_valid_o), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.fq_valid_i  = 1'b0;
    bus.dec_ready_i = 1'b0;
    check("rst_mid_count0", 64'(bus.count_o), 64'h0);
    check("rst_mid_dec_pc", 64'(bus.dec_pc_o), 64'h0);

    // Queue is usable again after the mid-stream reset
    step(1'b1, 32'h700, 32'h00b00013, 1'b0);
    check("post_rst_head", 64'(bus.dec_pc_o), 64'h700);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("sb_empty_end", 64'(sb.size()), 64'h0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
